// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: latches two operands and a carry-in, then adds one bit pair
// per clock through a single full-adder cell, LSB first, into a registered sum/co.

module fulladder_1 (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; sum/co hold the last result
// RUN   | one operand bit pair per clock through the full adder
// DONE  | single-cycle done pulse; start here is accepted back-to-back
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CNT_W-1:0] bit_cnt;
    logic             accept;
    logic             last_bit;
    logic             fa_s;
    logic             fa_co;

    fulladder_1 u_fa (
        .a  (op_a[0]),
        .b  (op_b[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = start ? RUN : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // co is only written on the final bit so it holds the previous result while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a    <= '0;
            op_b    <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
            sum     <= '0;
            co      <= 1'b0;
        end else if (accept) begin
            op_a    <= a;
            op_b    <= b;
            carry   <= ci;
            bit_cnt <= '0;
            sum     <= '0;
        end else if (state == RUN) begin
            op_a    <= op_a >> 1;
            op_b    <= op_b >> 1;
            carry   <= fa_co;
            bit_cnt <= bit_cnt + CNT_W'(1);
            sum     <= {fa_s, sum[WIDTH-1:1]};
            if (last_bit) begin
                co <= fa_co;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized and directed bench for serial_adder_ctrl; results are compared
// against plain a+b+ci arithmetic and the documented cycle timing.

module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             co;

    int n_checks;
    int n_fail;
    int n_done;
    int n_acc;

    logic [WIDTH-1:0] exp_sum;
    logic             exp_co;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .co    (co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) n_done++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Caller is at a negedge with the DUT in IDLE or DONE. Returns at the
    // negedge of the DONE cycle, with start already dropped.
    task automatic do_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vci);
        logic [WIDTH:0] total;
        total   = {1'b0, va} + {1'b0, vb} + {{WIDTH{1'b0}}, vci};
        exp_sum = total[WIDTH-1:0];
        exp_co  = total[WIDTH];
        start = 1'b1;
        a     = va;
        b     = vb;
        ci    = vci;
        @(posedge clk);
        #1;
        n_acc++;
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        ci    = 1'($urandom);
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            check("busy_run", 64'(busy), 64'd1);
            check("done_run", 64'(done), 64'd0);
            if (i == WIDTH / 2) begin
                start = 1'b1;
                a     = WIDTH'($urandom);
                b     = WIDTH'($urandom);
            end
        end
        start = 1'b0;
        @(negedge clk);
        check("done_pulse", 64'(done), 64'd1);
        check("busy_done", 64'(busy), 64'd0);
        check("sum", 64'(sum), 64'(exp_sum));
        check("co", 64'(co), 64'(exp_co));
    endtask

    task automatic idle_hold(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check("done_idle", 64'(done), 64'd0);
            check("busy_idle", 64'(busy), 64'd0);
            check("sum_hold", 64'(sum), 64'(exp_sum));
            check("co_hold", 64'(co), 64'(exp_co));
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_done   = 0;
        n_acc    = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        ci       = 1'b0;
        exp_sum  = '0;
        exp_co   = 1'b0;

        // reset then idle
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_co", 64'(co), 64'd0);
        rst_n = 1'b1;
        idle_hold(5);

        // directed operands
        do_op(8'h3C, 8'h15, 1'b0);
        check("dir_3c15", 64'({co, sum}), 64'h051);
        idle_hold(10);
        do_op(8'hFF, 8'h01, 1'b0);
        check("dir_ff01", 64'({co, sum}), 64'h100);
        idle_hold(2);
        do_op(8'hFF, 8'hFF, 1'b1);
        check("dir_ffff1", 64'({co, sum}), 64'h1FF);
        idle_hold(2);

        // back-to-back: second start accepted in the DONE cycle
        do_op(8'h01, 8'h01, 1'b0);
        check("b2b_first", 64'({co, sum}), 64'h002);
        do_op(8'h80, 8'h80, 1'b0);
        check("b2b_second", 64'({co, sum}), 64'h100);
        idle_hold(2);

        // asynchronous reset in the middle of a run
        start = 1'b1;
        a     = 8'h5A;
        b     = 8'h33;
        ci    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_sum", 64'(sum), 64'd0);
        check("mid_rst_co", 64'(co), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n   = 1'b1;
        exp_sum = '0;
        exp_co  = 1'b0;
        idle_hold(WIDTH + 3);
        do_op(8'h5A, 8'h33, 1'b1);
        check("post_rst", 64'({co, sum}), 64'h08E);
        idle_hold(1);

        // random regression with random gaps (0 = back-to-back)
        for (int n = 0; n < 1000; n++) begin
            do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            idle_hold(int'($urandom_range(0, 3)));
        end
        idle_hold(2);

        check("done_count", 64'(n_done), 64'(n_acc));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
